// File: rtl/mycpu_pkg.sv
// Shared definitions for the writeback/commit stage: commit-queue entry layout,
// exception codes and CSR field widths.
package mycpu_pkg;

    localparam int CSR_NUM_W    = 14;
    localparam int ECODE_W      = 6;
    localparam int ESUBCODE_W   = 9;
    localparam logic [ECODE_W-1:0]    ECODE_INT    = 6'h00;
    localparam logic [ESUBCODE_W-1:0] ESUBCODE_INT = 9'h000;

    // Width-independent control fields of a queued instruction.
    typedef struct packed {
        logic                  csr_we;
        logic                  ertn;
        logic [ECODE_W-1:0]    ecode;
        logic [ESUBCODE_W-1:0] esubcode;
        logic [CSR_NUM_W-1:0]  csr_num;
    } ws_ctrl_t;

    // Flags needed by forwarding; kept next to dest/result in the low bits of an entry.
    typedef struct packed {
        logic ex;
        logic csr_re;
        logic gr_we;
    } ws_flags_t;

    // Entry layout, MSB first:
    // {ws_ctrl_t, pc, csr_wmask, csr_wvalue, badv, ws_flags_t, dest, result}
    function automatic int ms_to_ws_w(input int data_w, input int reg_aw);
        return $bits(ws_ctrl_t) + $bits(ws_flags_t) + reg_aw + 5 * data_w;
    endfunction

    function automatic int ws_fwd_w(input int data_w, input int reg_aw);
        return $bits(ws_flags_t) + reg_aw + data_w;
    endfunction

endpackage

// File: rtl/wb_commit_fifo.sv
// Generic circular buffer with synchronous flush, occupancy count and a
// per-slot read-out of the low PEEK_W bits of every occupied entry.
module wb_commit_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int PEEK_W = WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [DEPTH*PEEK_W-1:0]    entry_peek
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic             do_push;

    // A flush wins over a same-cycle push so nothing younger than the flushing
    // instruction survives.
    assign do_push = push && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[tail_ptr] <= wdata;
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[head_ptr];

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PW'(PW'(i) - head_ptr)} < count);
            entry_peek[i*PEEK_W +: PEEK_W] = mem[i][PEEK_W-1:0];
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: small in-order commit queue that retires one
// instruction per cycle from its head and exports forwarding for every entry.
module wb_commit_stage
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 64
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     ms_valid,
    output logic                     ws_allowin,
    input  logic [DATA_W-1:0]        ms_pc,
    input  logic                     ms_gr_we,
    input  logic [REG_AW-1:0]        ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic                     ms_csr_re,
    input  logic                     ms_csr_we,
    input  logic [CSR_NUM_W-1:0]     ms_csr_num,
    input  logic [DATA_W-1:0]        ms_csr_wmask,
    input  logic [DATA_W-1:0]        ms_csr_wvalue,
    input  logic                     ms_ex,
    input  logic [ECODE_W-1:0]       ms_ecode,
    input  logic [ESUBCODE_W-1:0]    ms_esubcode,
    input  logic [DATA_W-1:0]        ms_badv,
    input  logic                     ms_ertn,

    output logic                     csr_re,
    output logic                     csr_we,
    output logic [CSR_NUM_W-1:0]     csr_num,
    output logic [DATA_W-1:0]        csr_wmask,
    output logic [DATA_W-1:0]        csr_wvalue,
    input  logic [DATA_W-1:0]        csr_rvalue,
    input  logic                     csr_has_int,
    input  logic [DATA_W-1:0]        csr_eentry,
    input  logic [DATA_W-1:0]        csr_era,

    output logic                     wb_ex,
    output logic [ECODE_W-1:0]       wb_ecode,
    output logic [ESUBCODE_W-1:0]    wb_esubcode,
    output logic [DATA_W-1:0]        wb_pc,
    output logic [DATA_W-1:0]        wb_vaddr,
    output logic                     ertn_flush,

    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,

    output logic [QDEPTH-1:0]        fwd_valid,
    output logic [QDEPTH*REG_AW-1:0] fwd_dest,
    output logic [QDEPTH*DATA_W-1:0] fwd_data,
    output logic [QDEPTH-1:0]        fwd_pending,

    output logic                     flush_pipe,
    output logic [DATA_W-1:0]        flush_target,

    input  logic                     trace_ready,
    output logic [DATA_W-1:0]        debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [REG_AW-1:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata,

    output logic [CNT_W-1:0]         instret
);

    localparam int ENTRY_W = ms_to_ws_w(DATA_W, REG_AW);
    localparam int FWD_W   = ws_fwd_w(DATA_W, REG_AW);
    localparam int CW      = $clog2(QDEPTH) + 1;

    logic [CW-1:0]             count;
    logic                      head_valid;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head_data;
    logic [QDEPTH-1:0]         entry_valid;
    logic [QDEPTH*FWD_W-1:0]   entry_peek;

    ws_ctrl_t                  push_ctrl;
    ws_flags_t                 push_flags;

    ws_ctrl_t                  head_ctrl;
    ws_flags_t                 head_flags;
    logic [DATA_W-1:0]         head_pc;
    logic [DATA_W-1:0]         head_wmask;
    logic [DATA_W-1:0]         head_wvalue;
    logic [DATA_W-1:0]         head_badv;
    logic [REG_AW-1:0]         head_dest;
    logic [DATA_W-1:0]         head_result;

    logic                      push;
    logic                      commit_fire;
    logic                      take_int;

    assign push_ctrl  = '{csr_we:   ms_csr_we,
                          ertn:     ms_ertn,
                          ecode:    ms_ecode,
                          esubcode: ms_esubcode,
                          csr_num:  ms_csr_num};
    assign push_flags = '{ex: ms_ex, csr_re: ms_csr_re, gr_we: ms_gr_we};
    assign push_entry = {push_ctrl, ms_pc, ms_csr_wmask, ms_csr_wvalue, ms_badv,
                         push_flags, ms_dest, ms_result};

    assign push = ms_valid && ws_allowin;

    wb_commit_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (QDEPTH),
        .PEEK_W (FWD_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_pipe),
        .push        (push),
        .wdata       (push_entry),
        .pop         (commit_fire),
        .count       (count),
        .head_valid  (head_valid),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_peek  (entry_peek)
    );

    assign {head_ctrl, head_pc, head_wmask, head_wvalue, head_badv,
            head_flags, head_dest, head_result} = head_data;

    // Popping the head this cycle frees a slot, so a full queue still accepts.
    assign ws_allowin  = (count < CW'(QDEPTH)) || commit_fire;
    assign commit_fire = head_valid && trace_ready;

    // A pending interrupt is taken on an ordinary instruction, which then
    // commits as an exception instead of retiring.
    assign take_int    = commit_fire && csr_has_int && !head_flags.ex && !head_ctrl.ertn;
    assign wb_ex       = commit_fire && (head_flags.ex || take_int);
    assign ertn_flush  = commit_fire && head_ctrl.ertn && !take_int;
    assign wb_ecode    = take_int ? ECODE_INT : head_ctrl.ecode;
    assign wb_esubcode = take_int ? ESUBCODE_INT : head_ctrl.esubcode;
    assign wb_pc       = head_pc;
    assign wb_vaddr    = head_badv;

    assign csr_re      = head_valid && head_flags.csr_re;
    assign csr_we      = commit_fire && head_ctrl.csr_we && !wb_ex;
    assign csr_num     = head_ctrl.csr_num;
    assign csr_wmask   = head_wmask;
    assign csr_wvalue  = head_wvalue;

    assign rf_we       = commit_fire && (head_flags.gr_we || head_flags.csr_re) && !wb_ex;
    assign rf_waddr    = head_dest;
    assign rf_wdata    = head_flags.csr_re ? csr_rvalue : head_result;

    assign flush_pipe   = wb_ex || ertn_flush;
    assign flush_target = wb_ex ? csr_eentry : csr_era;

    assign debug_wb_pc       = head_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = head_dest;
    assign debug_wb_rf_wdata = rf_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (commit_fire && !wb_ex) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // Forwarding view per physical slot; a queued CSR read has no data yet.
    for (genvar i = 0; i < QDEPTH; i++) begin : g_fwd
        ws_flags_t slot_flags;

        assign {slot_flags, fwd_dest[i*REG_AW +: REG_AW], fwd_data[i*DATA_W +: DATA_W]} =
            entry_peek[i*FWD_W +: FWD_W];
        assign fwd_valid[i]   = entry_valid[i] && (slot_flags.gr_we || slot_flags.csr_re)
                                && !slot_flags.ex;
        assign fwd_pending[i] = entry_valid[i] && slot_flags.csr_re;
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed, table-driven bench for wb_commit_stage: one vector per cycle with
// hand-computed expectations, plus CSR-write and reset-with-full-queue sequences.
module tb_wb_commit_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int QDEPTH = 2;
    localparam int CNT_W  = 64;
    localparam int NVEC   = 27;

    logic                     clk;
    logic                     reset;
    logic                     ms_valid;
    logic                     ws_allowin;
    logic [DATA_W-1:0]        ms_pc;
    logic                     ms_gr_we;
    logic [REG_AW-1:0]        ms_dest;
    logic [DATA_W-1:0]        ms_result;
    logic                     ms_csr_re;
    logic                     ms_csr_we;
    logic [13:0]              ms_csr_num;
    logic [DATA_W-1:0]        ms_csr_wmask;
    logic [DATA_W-1:0]        ms_csr_wvalue;
    logic                     ms_ex;
    logic [5:0]               ms_ecode;
    logic [8:0]               ms_esubcode;
    logic [DATA_W-1:0]        ms_badv;
    logic                     ms_ertn;
    logic                     csr_re;
    logic                     csr_we;
    logic [13:0]              csr_num;
    logic [DATA_W-1:0]        csr_wmask;
    logic [DATA_W-1:0]        csr_wvalue;
    logic [DATA_W-1:0]        csr_rvalue;
    logic                     csr_has_int;
    logic [DATA_W-1:0]        csr_eentry;
    logic [DATA_W-1:0]        csr_era;
    logic                     wb_ex;
    logic [5:0]               wb_ecode;
    logic [8:0]               wb_esubcode;
    logic [DATA_W-1:0]        wb_pc;
    logic [DATA_W-1:0]        wb_vaddr;
    logic                     ertn_flush;
    logic                     rf_we;
    logic [REG_AW-1:0]        rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic [QDEPTH-1:0]        fwd_valid;
    logic [QDEPTH*REG_AW-1:0] fwd_dest;
    logic [QDEPTH*DATA_W-1:0] fwd_data;
    logic [QDEPTH-1:0]        fwd_pending;
    logic                     flush_pipe;
    logic [DATA_W-1:0]        flush_target;
    logic                     trace_ready;
    logic [DATA_W-1:0]        debug_wb_pc;
    logic [3:0]               debug_wb_rf_wen;
    logic [REG_AW-1:0]        debug_wb_rf_wnum;
    logic [DATA_W-1:0]        debug_wb_rf_wdata;
    logic [CNT_W-1:0]         instret;

    wb_commit_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_valid          (ms_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_csr_re         (ms_csr_re),
        .ms_csr_we         (ms_csr_we),
        .ms_csr_num        (ms_csr_num),
        .ms_csr_wmask      (ms_csr_wmask),
        .ms_csr_wvalue     (ms_csr_wvalue),
        .ms_ex             (ms_ex),
        .ms_ecode          (ms_ecode),
        .ms_esubcode       (ms_esubcode),
        .ms_badv           (ms_badv),
        .ms_ertn           (ms_ertn),
        .csr_re            (csr_re),
        .csr_we            (csr_we),
        .csr_num           (csr_num),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .csr_rvalue        (csr_rvalue),
        .csr_has_int       (csr_has_int),
        .csr_eentry        (csr_eentry),
        .csr_era           (csr_era),
        .wb_ex             (wb_ex),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_pc             (wb_pc),
        .wb_vaddr          (wb_vaddr),
        .ertn_flush        (ertn_flush),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_data          (fwd_data),
        .fwd_pending       (fwd_pending),
        .flush_pipe        (flush_pipe),
        .flush_target      (flush_target),
        .trace_ready       (trace_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .instret           (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs of one cycle and the outputs expected in that same cycle.
    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        ex;
        logic        ertn;
        logic        csrre;
        logic        tr;
        logic        intr;
        logic        e_allow;
        logic        e_rfwe;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_wbex;
        logic [5:0]  e_ecode;
        logic        e_ertn;
        logic        e_flush;
        logic [31:0] e_ftgt;
        logic [1:0]  e_fwdv;
        logic [1:0]  e_fwdp;
        logic [63:0] e_instret;
    } vec_t;

    vec_t vecs [NVEC];
    int   total;
    int   bad;

    function automatic vec_t mk(input int v, input int we, input int dest, input int res,
                                input int ex, input int ertn, input int csrre, input int tr,
                                input int intr, input int allow, input int rfwe, input int waddr,
                                input int wdata, input int wbex, input int ecode, input int ertnf,
                                input int flush, input int ftgt, input int fwdv, input int fwdp,
                                input int ninstret);
        vec_t t;
        t.v         = 1'(v);
        t.we        = 1'(we);
        t.dest      = 5'(dest);
        t.res       = 32'(res);
        t.ex        = 1'(ex);
        t.ertn      = 1'(ertn);
        t.csrre     = 1'(csrre);
        t.tr        = 1'(tr);
        t.intr      = 1'(intr);
        t.e_allow   = 1'(allow);
        t.e_rfwe    = 1'(rfwe);
        t.e_waddr   = 5'(waddr);
        t.e_wdata   = 32'(wdata);
        t.e_wbex    = 1'(wbex);
        t.e_ecode   = 6'(ecode);
        t.e_ertn    = 1'(ertnf);
        t.e_flush   = 1'(flush);
        t.e_ftgt    = 32'(ftgt);
        t.e_fwdv    = 2'(fwdv);
        t.e_fwdp    = 2'(fwdp);
        t.e_instret = 64'(ninstret);
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t t, input int idx);
        ms_valid    = t.v;
        ms_pc       = 32'h1c000000 + 32'(idx * 4);
        ms_gr_we    = t.we;
        ms_dest     = t.dest;
        ms_result   = t.res;
        ms_ex       = t.ex;
        ms_ertn     = t.ertn;
        ms_csr_re   = t.csrre;
        ms_csr_we   = 1'b0;
        trace_ready = t.tr;
        csr_has_int = t.intr;
    endtask

    task automatic check_output(input vec_t t, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " allowin"}, 64'(ws_allowin), 64'(t.e_allow));
        check({tag, " rf_we"}, 64'(rf_we), 64'(t.e_rfwe));
        check({tag, " dbg_wen"}, 64'(debug_wb_rf_wen), 64'({4{t.e_rfwe}}));
        if (t.e_rfwe) begin
            check({tag, " rf_waddr"}, 64'(rf_waddr), 64'(t.e_waddr));
            check({tag, " rf_wdata"}, 64'(rf_wdata), 64'(t.e_wdata));
            check({tag, " dbg_wdata"}, 64'(debug_wb_rf_wdata), 64'(t.e_wdata));
        end
        check({tag, " wb_ex"}, 64'(wb_ex), 64'(t.e_wbex));
        if (t.e_wbex) begin
            check({tag, " wb_ecode"}, 64'(wb_ecode), 64'(t.e_ecode));
        end
        check({tag, " ertn_flush"}, 64'(ertn_flush), 64'(t.e_ertn));
        check({tag, " flush_pipe"}, 64'(flush_pipe), 64'(t.e_flush));
        if (t.e_flush) begin
            check({tag, " flush_target"}, 64'(flush_target), 64'(t.e_ftgt));
        end
        check({tag, " fwd_valid"}, 64'(fwd_valid), 64'(t.e_fwdv));
        check({tag, " fwd_pending"}, 64'(fwd_pending), 64'(t.e_fwdp));
        check({tag, " csr_re"}, 64'(csr_re), 64'(|t.e_fwdp));
        check({tag, " instret"}, instret, t.e_instret);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;

        //             v we  d   res   ex er cr tr in | al rw wa  wdata  wx ec er fl ftgt          fv fp inst
        vecs[0]  = mk(1, 1,  1, 'h11,   0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 0);
        vecs[1]  = mk(1, 1,  2, 'h22,   0, 0, 0, 1, 0,  1, 1, 1,  'h11,   0, 0,  0, 0, 0,            1, 0, 0);
        vecs[2]  = mk(1, 1,  3, 'h33,   0, 0, 0, 1, 0,  1, 1, 2,  'h22,   0, 0,  0, 0, 0,            2, 0, 1);
        vecs[3]  = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 1, 3,  'h33,   0, 0,  0, 0, 0,            1, 0, 2);
        vecs[4]  = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 3);
        vecs[5]  = mk(1, 1,  4, 'h44,   0, 0, 0, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 3);
        vecs[6]  = mk(1, 1,  5, 'h55,   0, 0, 0, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            2, 0, 3);
        vecs[7]  = mk(1, 1,  6, 'h66,   0, 0, 0, 0, 0,  0, 0, 0,  0,      0, 0,  0, 0, 0,            3, 0, 3);
        vecs[8]  = mk(1, 1,  6, 'h66,   0, 0, 0, 0, 0,  0, 0, 0,  0,      0, 0,  0, 0, 0,            3, 0, 3);
        vecs[9]  = mk(1, 1,  6, 'h66,   0, 0, 0, 1, 0,  1, 1, 4,  'h44,   0, 0,  0, 0, 0,            3, 0, 3);
        vecs[10] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 1, 5,  'h55,   0, 0,  0, 0, 0,            3, 0, 4);
        vecs[11] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 1, 6,  'h66,   0, 0,  0, 0, 0,            2, 0, 5);
        vecs[12] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[13] = mk(1, 1,  7, 'h77,   1, 0, 0, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[14] = mk(1, 1,  8, 'h88,   0, 0, 0, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[15] = mk(1, 1,  9, 'h99,   0, 0, 0, 1, 0,  1, 0, 0,  0,      1, 11, 0, 1, 'h1c008000,   2, 0, 6);
        vecs[16] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[17] = mk(1, 1, 10, 'hAA,   0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[18] = mk(0, 0,  0, 0,      0, 0, 0, 1, 1,  1, 0, 0,  0,      1, 0,  0, 1, 'h1c008000,   1, 0, 6);
        vecs[19] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[20] = mk(1, 0,  0, 0,      0, 1, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 6);
        vecs[21] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  1, 1, 'h1c000100,   0, 0, 6);
        vecs[22] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 7);
        vecs[23] = mk(1, 0,  5, 0,      0, 0, 1, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 7);
        vecs[24] = mk(0, 0,  0, 0,      0, 0, 0, 0, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            1, 1, 7);
        vecs[25] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 1, 5,  'hDEAD, 0, 0,  0, 0, 0,            1, 1, 7);
        vecs[26] = mk(0, 0,  0, 0,      0, 0, 0, 1, 0,  1, 0, 0,  0,      0, 0,  0, 0, 0,            0, 0, 8);

        reset         = 1'b1;
        ms_valid      = 1'b0;
        ms_pc         = '0;
        ms_gr_we      = 1'b0;
        ms_dest       = '0;
        ms_result     = '0;
        ms_csr_re     = 1'b0;
        ms_csr_we     = 1'b0;
        ms_csr_num    = '0;
        ms_csr_wmask  = '0;
        ms_csr_wvalue = '0;
        ms_ex         = 1'b0;
        ms_ecode      = 6'h0B;
        ms_esubcode   = '0;
        ms_badv       = '0;
        ms_ertn       = 1'b0;
        csr_rvalue    = 32'h0000DEAD;
        csr_has_int   = 1'b0;
        csr_eentry    = 32'h1c008000;
        csr_era       = 32'h1c000100;
        trace_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset allowin", 64'(ws_allowin), 64'd1);
        check("reset instret", instret, 64'd0);
        check("reset rf_we", 64'(rf_we), 64'd0);
        check("reset flush", 64'(flush_pipe), 64'd0);
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i], i);
            @(negedge clk);
            check_output(vecs[i], i);
            next_cycle();
        end

        // CSR write commits with mask/value; a later one converted by an interrupt does not.
        ms_valid      = 1'b1;
        ms_gr_we      = 1'b0;
        ms_csr_re     = 1'b0;
        ms_csr_we     = 1'b1;
        ms_csr_num    = 14'h006;
        ms_csr_wmask  = 32'hFFFF0000;
        ms_csr_wvalue = 32'h12345678;
        trace_ready   = 1'b1;
        csr_has_int   = 1'b0;
        next_cycle();
        ms_valid = 1'b0;
        @(negedge clk);
        check("csrwr csr_we", 64'(csr_we), 64'd1);
        check("csrwr csr_num", 64'(csr_num), 64'h6);
        check("csrwr wmask", 64'(csr_wmask), 64'hFFFF0000);
        check("csrwr wvalue", 64'(csr_wvalue), 64'h12345678);
        check("csrwr rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        check("csrwr instret", instret, 64'd9);
        ms_valid    = 1'b1;
        trace_ready = 1'b0;
        next_cycle();
        ms_valid    = 1'b0;
        trace_ready = 1'b1;
        csr_has_int = 1'b1;
        @(negedge clk);
        check("int csr_we", 64'(csr_we), 64'd0);
        check("int wb_ex", 64'(wb_ex), 64'd1);
        check("int wb_esubcode", 64'(wb_esubcode), 64'd0);
        next_cycle();
        csr_has_int = 1'b0;
        ms_csr_we   = 1'b0;
        check("int instret", instret, 64'd9);

        // Fill the queue while stalled, then reset with it full.
        ms_valid    = 1'b1;
        ms_gr_we    = 1'b1;
        ms_dest     = 5'd9;
        ms_result   = 32'h99;
        trace_ready = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("full allowin", 64'(ws_allowin), 64'd0);
        check("full fwd_valid", 64'(fwd_valid), 64'h3);
        next_cycle();
        reset       = 1'b1;
        trace_ready = 1'b1;
        next_cycle();
        reset    = 1'b0;
        ms_valid = 1'b0;
        @(negedge clk);
        check("rst allowin", 64'(ws_allowin), 64'd1);
        check("rst rf_we", 64'(rf_we), 64'd0);
        check("rst wb_ex", 64'(wb_ex), 64'd0);
        check("rst flush", 64'(flush_pipe), 64'd0);
        check("rst dbg_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("rst fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst instret", instret, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
